bcd_decade_counter: RTL and testbench

Multi-digit synchronous BCD (8421) decade counter that generates the digit stream consumed by the downstream BCD-to-Excess-3 converter stage. Each digit is a registered 4-bit nibble, MSB first (bit 3 = A, bit 0 = D), and is always a legal BCD code 0–9. The block supports parallel load with BCD validity checking, a programmable tick prescaler and a terminal-count pulse for cascading. Down-counting is optional and compiled in by macro.

---
 rtl/bcd_decade_counter.sv | 135 +++++++++++++
 tb/tb_bcd_decade_counter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_decade_counter.sv
// -----------------------------------------------------------------------------
// bcd_decade_counter
//
// Multi-digit synchronous BCD (8421) decade counter. Produces the digit stream
// for the downstream BCD-to-Excess-3 stage. Every nibble of the count is held
// in the legal range 0..9 at all times.
//
// Features:
//   - parallel load with BCD validity check (invalid loads are rejected)
//   - programmable prescaler: one count step per TICK_DIV enabled edges
//   - one-cycle terminal-count pulse (tc) on wrap, for cascading
//   - optional down counting, compiled in with the macro BCD_DOWN_COUNT_EN
//
// Parameters:
//   NDIG      number of BCD digits (1..4)
//   TICK_DIV  enabled edges per count step (1..255)
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   en        in   count enable
//   load      in   parallel load strobe (wins over en)
//   load_val  in   4*NDIG load value, digit 0 in [3:0]
//   dn        in   direction, 1 = down (only with BCD_DOWN_COUNT_EN)
//   bcd       out  registered count, digit 0 in [3:0]
//   tc        out  one-cycle pulse after a wrap step
//   load_err  out  one-cycle pulse after a rejected load
//   step      out  one-cycle pulse after any count step
//
// Priority on each edge: load, then count, then hold. All outputs are
// registered; pulses are cleared every edge unless re-caused.
// -----------------------------------------------------------------------------
module bcd_decade_counter #(
   parameter int NDIG     = 2,
   parameter int TICK_DIV = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              load,
   input  logic [4*NDIG-1:0] load_val,
`ifdef BCD_DOWN_COUNT_EN
   input  logic              dn,
`endif
   output logic [4*NDIG-1:0] bcd,
   output logic              tc,
   output logic              load_err,
   output logic              step
);

   // Prescaler value at which the next enabled edge becomes a count step.
   localparam logic [7:0] PRESC_LAST = 8'(TICK_DIV - 1);

   logic [7:0]        presc;
   logic [4*NDIG-1:0] bcd_next;
   logic              wrap;
   logic              load_ok;
   logic [3:0]        digit;
   logic              carry;

   // A load is accepted only if every nibble is a legal BCD code.
   always_comb begin
      load_ok = 1'b1;
      for (int i = 0; i < NDIG; i++) begin
         if (load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;
      end
   end

   // Next count value for a step. The carry (or borrow) ripples through all
   // digits in one cycle; a carry out of the top digit means the whole
   // counter wrapped, which is exactly the terminal-count condition.
   always_comb begin
      bcd_next = bcd;
      carry    = 1'b1;
      digit    = 4'd0;
      for (int i = 0; i < NDIG; i++) begin
         digit = bcd[4*i +: 4];
         if (carry) begin
`ifdef BCD_DOWN_COUNT_EN
            if (dn) begin
               if (digit == 4'd0) begin
                  digit = 4'd9;
               end else begin
                  digit = digit - 4'd1;
                  carry = 1'b0;
               end
            end else
`endif
            begin
               if (digit == 4'd9) begin
                  digit = 4'd0;
               end else begin
                  digit = digit + 4'd1;
                  carry = 1'b0;
               end
            end
         end
         bcd_next[4*i +: 4] = digit;
      end
      wrap = carry;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd      <= '0;
         presc    <= 8'd0;
         tc       <= 1'b0;
         load_err <= 1'b0;
         step     <= 1'b0;
      end else begin
         tc       <= 1'b0;
         load_err <= 1'b0;
         step     <= 1'b0;
         if (load) begin
            // A rejected load leaves both count and prescaler untouched.
            if (load_ok) begin
               bcd   <= load_val;
               presc <= 8'd0;
            end else begin
               load_err <= 1'b1;
            end
         end else if (en) begin
            if (presc == PRESC_LAST) begin
               presc <= 8'd0;
               bcd   <= bcd_next;
               step  <= 1'b1;
               tc    <= wrap;
            end else begin
               presc <= presc + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_bcd_decade_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_decade_counter
//
// Two instances with NDIG = 2 share one stimulus stream: u0 with TICK_DIV = 1
// and u3 with TICK_DIV = 3. A decimal-integer reference model follows each
// instance. Directed tables and hand sequences add constant expectations.
// -----------------------------------------------------------------------------
module tb_bcd_decade_counter;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       load;
   logic       dn;
   logic [7:0] load_val;

   logic [7:0] bcd0, bcd3;
   logic       tc0, tc3, err0, err3, step0, step3;

   int n_cmp = 0;
   int n_bad = 0;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   bcd_decade_counter #(.NDIG(2), .TICK_DIV(1)) u0 (
      .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_val(load_val),
`ifdef BCD_DOWN_COUNT_EN
      .dn(dn),
`endif
      .bcd(bcd0), .tc(tc0), .load_err(err0), .step(step0)
   );

   bcd_decade_counter #(.NDIG(2), .TICK_DIV(3)) u3 (
      .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_val(load_val),
`ifdef BCD_DOWN_COUNT_EN
      .dn(dn),
`endif
      .bcd(bcd3), .tc(tc3), .load_err(err3), .step(step3)
   );

   // ---------------- reference model ----------------
   int   td[2] = '{1, 3};
   int   m_val[2];
   int   m_pre[2];
   logic m_tc[2], m_step[2], m_err[2];

   function automatic logic [7:0] to_bcd(input int v);
      logic [3:0] hi, lo;
      hi = 4'((v / 10) % 10);
      lo = 4'(v % 10);
      return {hi, lo};
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_val[k] = 0; m_pre[k] = 0;
         m_tc[k] = 1'b0; m_step[k] = 1'b0; m_err[k] = 1'b0;
      end
   endtask

   task automatic model_edge();
      logic down;
`ifdef BCD_DOWN_COUNT_EN
      down = dn;
`else
      down = 1'b0;
`endif
      for (int k = 0; k < 2; k++) begin
         m_tc[k] = 1'b0; m_step[k] = 1'b0; m_err[k] = 1'b0;
         if (load) begin
            if (load_val[7:4] <= 4'd9 && load_val[3:0] <= 4'd9) begin
               m_val[k] = int'(load_val[7:4]) * 10 + int'(load_val[3:0]);
               m_pre[k] = 0;
            end else begin
               m_err[k] = 1'b1;
            end
         end else if (en) begin
            m_pre[k]++;
            if (m_pre[k] == td[k]) begin
               m_pre[k]  = 0;
               m_step[k] = 1'b1;
               if (down) begin
                  m_tc[k]  = (m_val[k] == 0);
                  m_val[k] = (m_val[k] + 99) % 100;
               end else begin
                  m_tc[k]  = (m_val[k] == 99);
                  m_val[k] = (m_val[k] + 1) % 100;
               end
            end
         end
      end
   endtask

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      check("u0.bcd",  32'(bcd0),  32'(to_bcd(m_val[0])));
      check("u0.tc",   32'(tc0),   32'(m_tc[0]));
      check("u0.step", 32'(step0), 32'(m_step[0]));
      check("u0.err",  32'(err0),  32'(m_err[0]));
      check("u3.bcd",  32'(bcd3),  32'(to_bcd(m_val[1])));
      check("u3.tc",   32'(tc3),   32'(m_tc[1]));
      check("u3.step", 32'(step3), 32'(m_step[1]));
      check("u3.err",  32'(err3),  32'(m_err[1]));
   endtask

   // ---------------- driver ----------------
   // Inputs change at edge+1, the model advances at the edge, outputs are
   // sampled at edge+1 of the following edge.
   task automatic cycle(input logic e, input logic l, input logic [7:0] v, input logic d);
      en = e; load = l; load_val = v; dn = d;
      @(posedge clk);
      model_edge();
      #1;
      check_model();
   endtask

   typedef struct {
      logic       e;
      logic       l;
      logic [7:0] v;
      logic [7:0] exp_bcd;
      logic       exp_tc;
      logic       exp_step;
      logic       exp_err;
   } vec_t;

   vec_t vt[12];

   initial begin
      // Directed vectors, expectations for the TICK_DIV = 1 instance.
      vt[0]  = '{1'b0, 1'b1, 8'h58, 8'h58, 1'b0, 1'b0, 1'b0};
      vt[1]  = '{1'b0, 1'b1, 8'h5A, 8'h58, 1'b0, 1'b0, 1'b1};
      vt[2]  = '{1'b0, 1'b0, 8'h00, 8'h58, 1'b0, 1'b0, 1'b0};
      vt[3]  = '{1'b1, 1'b1, 8'h31, 8'h31, 1'b0, 1'b0, 1'b0};
      vt[4]  = '{1'b1, 1'b0, 8'h00, 8'h32, 1'b0, 1'b1, 1'b0};
      vt[5]  = '{1'b0, 1'b1, 8'h99, 8'h99, 1'b0, 1'b0, 1'b0};
      vt[6]  = '{1'b1, 1'b1, 8'h23, 8'h23, 1'b0, 1'b0, 1'b0};
      vt[7]  = '{1'b0, 1'b1, 8'h99, 8'h99, 1'b0, 1'b0, 1'b0};
      vt[8]  = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0};
      vt[9]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
      vt[10] = '{1'b1, 1'b1, 8'hA0, 8'h00, 1'b0, 1'b0, 1'b1};
      vt[11] = '{1'b1, 1'b0, 8'h00, 8'h01, 1'b0, 1'b1, 1'b0};

      rst_n = 1'b0; en = 1'b0; load = 1'b0; dn = 1'b0; load_val = 8'h00;
      model_reset();
      #12;
      check("reset.bcd0", 32'(bcd0), 32'h0);
      check("reset.bcd3", 32'(bcd3), 32'h0);
      check("reset.pulses", 32'({tc0, step0, err0, tc3, step3, err3}), 32'h0);
      rst_n = 1'b1;

      // Asynchronous reset mid-cycle while holding 47.
      cycle(1'b0, 1'b1, 8'h47, 1'b0);
      check("pre_reset.bcd0", 32'(bcd0), 32'h47);
      #3 rst_n = 1'b0;
      #1;
      check("async_reset.bcd0", 32'(bcd0), 32'h0);
      check("async_reset.bcd3", 32'(bcd3), 32'h0);
      check("async_reset.pulses", 32'({tc0, step0, err0, tc3, step3, err3}), 32'h0);
      model_reset();
      #2 rst_n = 1'b1;

      // Up count through the full 00..99..00 cycle.
      for (int i = 1; i <= 100; i++) begin
         cycle(1'b1, 1'b0, 8'h00, 1'b0);
         check("wrap.tc0", 32'(tc0), 32'(i == 100));
      end
      check("wrap.bcd0", 32'(bcd0), 32'h00);

      // Directed table: load, invalid load, priority, wrap.
      for (int i = 0; i < 12; i++) begin
         cycle(vt[i].e, vt[i].l, vt[i].v, 1'b0);
         check($sformatf("vec%0d.bcd", i),  32'(bcd0),  32'(vt[i].exp_bcd));
         check($sformatf("vec%0d.tc", i),   32'(tc0),   32'(vt[i].exp_tc));
         check($sformatf("vec%0d.step", i), 32'(step0), 32'(vt[i].exp_step));
         check($sformatf("vec%0d.err", i),  32'(err0),  32'(vt[i].exp_err));
      end

      // Prescaler on the TICK_DIV = 3 instance.
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
      for (int i = 1; i <= 7; i++) begin
         cycle(1'b1, 1'b0, 8'h00, 1'b0);
         if (i == 3) check("presc.e3", 32'(bcd3), 32'h01);
         if (i == 6) check("presc.e6", 32'(bcd3), 32'h02);
      end
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0);
      cycle(1'b1, 1'b0, 8'h00, 1'b0);
      check("presc.hold_bcd", 32'(bcd3), 32'h02);
      check("presc.hold_step", 32'(step3), 32'h0);
      cycle(1'b1, 1'b0, 8'h00, 1'b0);
      check("presc.resume_bcd", 32'(bcd3), 32'h03);
      check("presc.resume_step", 32'(step3), 32'h1);

`ifdef BCD_DOWN_COUNT_EN
      // Down count with borrow and 00 -> 99 wrap.
      cycle(1'b0, 1'b1, 8'h10, 1'b1);
      cycle(1'b1, 1'b0, 8'h00, 1'b1);
      check("down.09", 32'(bcd0), 32'h09);
      cycle(1'b1, 1'b0, 8'h00, 1'b1);
      check("down.08", 32'(bcd0), 32'h08);
      cycle(1'b0, 1'b1, 8'h00, 1'b1);
      cycle(1'b1, 1'b0, 8'h00, 1'b1);
      check("down.99", 32'(bcd0), 32'h99);
      check("down.tc", 32'(tc0), 32'h1);
`endif

      // Randomized stimulus against the model.
      for (int i = 0; i < 600; i++) begin
         logic       e, l, d;
         logic [7:0] v;
         e = ($urandom_range(0, 9) < 7);
         l = ($urandom_range(0, 9) == 0);
         d = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 1) == 1) v = 8'($urandom_range(0, 255));
         else v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
         cycle(e, l, v, d);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
